// File: rtl/pacman_pkg.sv
// Shared pacman types: direction encoding, ghost FSM states, maze constants
// and direction helpers.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PICK   = 3'd1,
        ST_QUERY  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    localparam int TILE_BITS = 3;
    localparam int MAP_W_DEF = 28;
    localparam int MAP_H_DEF = 31;

    function automatic logic [1:0] dir_rev(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction

    // Next direction clockwise, stepping over the reverse of the current heading.
    function automatic logic [1:0] dir_rot(input logic [1:0] d, input logic [1:0] cur);
        logic [1:0] n;
        n = d + 2'd1;
        n = (n == dir_rev(cur)) ? n + 2'd1 : n;
        return n;
    endfunction

endpackage

// File: rtl/ghost_dir_pick.sv
// Combinational first-candidate selection for a ghost decision: chase toward
// Pacman or take the random direction, then rotate away from a reversal.
module ghost_dir_pick
    import pacman_pkg::*;
#(
    parameter int CHASE_THRESH = 5
) (
    input  logic [4:0] tile_x,
    input  logic [4:0] tile_y,
    input  logic [4:0] pac_x,
    input  logic [4:0] pac_y,
    input  logic [1:0] rnd_dir,
    input  logic [2:0] rnd_percent,
    input  logic [1:0] cur_dir,
    input  logic       chase_en,
    output logic [1:0] cand
);

    logic [5:0] dx_s;
    logic [5:0] dy_s;
    logic [5:0] adx_s;
    logic [5:0] ady_s;
    logic       chase_s;
    logic [1:0] raw_s;

    assign dx_s    = {1'b0, pac_x} - {1'b0, tile_x};
    assign dy_s    = {1'b0, pac_y} - {1'b0, tile_y};
    assign adx_s   = dx_s[5] ? (6'd0 - dx_s) : dx_s;
    assign ady_s   = dy_s[5] ? (6'd0 - dy_s) : dy_s;
    assign chase_s = chase_en && ({1'b0, rnd_percent} < 4'(CHASE_THRESH));

    // Larger axis wins (ties go to x); screen y grows downward.
    always_comb begin
        raw_s = rnd_dir;
        if (chase_s && ((dx_s != 6'd0) || (dy_s != 6'd0))) begin
            if (adx_s >= ady_s) begin
                raw_s = dx_s[5] ? DIR_LEFT : DIR_RIGHT;
            end else begin
                raw_s = dy_s[5] ? DIR_UP : DIR_DOWN;
            end
        end else begin
            raw_s = rnd_dir;
        end
        cand = (raw_s == dir_rev(cur_dir)) ? raw_s + 2'd1 : raw_s;
    end

endmodule

// File: rtl/ghost_mover.sv
// Per-ghost movement controller: one pixel per frame tick, wall-checked turn
// decision at tile centres. Optional half-speed frightened mode: GHOST_FRIGHT_EN.
module ghost_mover
    import pacman_pkg::*;
#(
    parameter int MAP_W        = MAP_W_DEF,
    parameter int MAP_H        = MAP_H_DEF,
    parameter int START_X      = 13,
    parameter int START_Y      = 11,
    parameter int CHASE_THRESH = 5
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       frame_tick,
    input  logic [1:0] rnd_dir,
    input  logic [2:0] rnd_percent,
    input  logic [4:0] pac_tile_x,
    input  logic [4:0] pac_tile_y,
    output logic [4:0] wall_q_x,
    output logic [4:0] wall_q_y,
    input  logic       wall_q_hit,
    input  logic       fright,
    output logic [7:0] ghost_x,
    output logic [7:0] ghost_y,
    output logic [1:0] ghost_dir,
    output logic       busy
);

    localparam logic [7:0] X_LAST  = 8'(MAP_W * 8 - 1);
    localparam logic [7:0] Y_LAST  = 8'(MAP_H * 8 - 1);
    localparam logic [4:0] TX_LAST = 5'(MAP_W - 1);
    localparam logic [4:0] TY_LAST = 5'(MAP_H - 1);
    localparam logic [7:0] X_RST   = 8'(START_X * 8);
    localparam logic [7:0] Y_RST   = 8'(START_Y * 8);

    state_e     state_r, state_nxt;
    logic [7:0] x_r, x_nxt, y_r, y_nxt;
    logic [1:0] dir_r, dir_nxt, cand_r, cand_nxt, tries_r, tries_nxt, pick_s;
    logic [4:0] wq_x_r, wq_x_nxt, wq_y_r, wq_y_nxt;
    logic       boxed_r, boxed_nxt, pend_r, pend_nxt, busy_r;
    logic       tick_s, centred_s, chase_en_s, move_ok_s;
    logic [4:0] tile_x_s, tile_y_s;

    function automatic logic [9:0] nb_tile(input logic [1:0] d, input logic [4:0] tx,
                                           input logic [4:0] ty);
        logic [4:0] nx, ny;
        nx = tx;
        ny = ty;
        case (d)
            DIR_UP:    ny = (ty == 5'd0) ? TY_LAST : ty - 5'd1;
            DIR_RIGHT: nx = (tx == TX_LAST) ? 5'd0 : tx + 5'd1;
            DIR_DOWN:  ny = (ty == TY_LAST) ? 5'd0 : ty + 5'd1;
            DIR_LEFT:  nx = (tx == 5'd0) ? TX_LAST : tx - 5'd1;
            default:   nx = tx;
        endcase
        return {nx, ny};
    endfunction

    function automatic logic [15:0] step_pix(input logic [1:0] d, input logic [7:0] px,
                                             input logic [7:0] py);
        logic [7:0] nx, ny;
        nx = px;
        ny = py;
        case (d)
            DIR_UP:    ny = (py == 8'd0) ? Y_LAST : py - 8'd1;
            DIR_RIGHT: nx = (px == X_LAST) ? 8'd0 : px + 8'd1;
            DIR_DOWN:  ny = (py == Y_LAST) ? 8'd0 : py + 8'd1;
            DIR_LEFT:  nx = (px == 8'd0) ? X_LAST : px - 8'd1;
            default:   nx = px;
        endcase
        return {nx, ny};
    endfunction

    assign tile_x_s  = x_r[7:TILE_BITS];
    assign tile_y_s  = y_r[7:TILE_BITS];
    assign centred_s = (x_r[TILE_BITS-1:0] == 3'd0) && (y_r[TILE_BITS-1:0] == 3'd0);
    assign tick_s    = frame_tick | pend_r;

`ifdef GHOST_FRIGHT_EN
    logic tog_r, fright_d_r;

    assign chase_en_s = !fright;
    assign move_ok_s  = !fright || tog_r;

    // Half-speed gate: flips on each consumed tick while frightened, cleared when fright drops.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tog_r      <= 1'b0;
            fright_d_r <= 1'b0;
        end else begin
            fright_d_r <= fright;
            if (fright_d_r && !fright) begin
                tog_r <= 1'b0;
            end else if (fright && (state_r == ST_IDLE) && tick_s) begin
                tog_r <= !tog_r;
            end else begin
                tog_r <= tog_r;
            end
        end
    end
`else
    logic fright_unused_s;

    assign fright_unused_s = fright;
    assign chase_en_s      = 1'b1;
    assign move_ok_s       = 1'b1;
`endif

    ghost_dir_pick #(
        .CHASE_THRESH(CHASE_THRESH)
    ) u_pick (
        .tile_x     (tile_x_s),
        .tile_y     (tile_y_s),
        .pac_x      (pac_tile_x),
        .pac_y      (pac_tile_y),
        .rnd_dir    (rnd_dir),
        .rnd_percent(rnd_percent),
        .cur_dir    (dir_r),
        .chase_en   (chase_en_s),
        .cand       (pick_s)
    );

    // Decision FSM next-state, motion and wall-query address.
    always_comb begin
        state_nxt = state_r;
        x_nxt     = x_r;
        y_nxt     = y_r;
        dir_nxt   = dir_r;
        cand_nxt  = cand_r;
        tries_nxt = tries_r;
        boxed_nxt = boxed_r;
        wq_x_nxt  = wq_x_r;
        wq_y_nxt  = wq_y_r;
        pend_nxt  = (state_r == ST_IDLE) ? 1'b0 : (pend_r | frame_tick);
        case (state_r)
            ST_IDLE: begin
                if (tick_s && move_ok_s) begin
                    if (centred_s) begin
                        state_nxt = ST_PICK;
                    end else begin
                        {x_nxt, y_nxt} = step_pix(dir_r, x_r, y_r);
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PICK: begin
                cand_nxt   = pick_s;
                tries_nxt  = 2'd0;
                boxed_nxt  = 1'b0;
                {wq_x_nxt, wq_y_nxt} = nb_tile(pick_s, tile_x_s, tile_y_s);
                state_nxt  = ST_QUERY;
            end
            ST_QUERY: begin
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                // Three forward-ish tries, then the reverse; a blocked reverse means boxed in.
                if (!wall_q_hit) begin
                    state_nxt = ST_COMMIT;
                end else if (tries_r == 2'd3) begin
                    boxed_nxt = 1'b1;
                    state_nxt = ST_COMMIT;
                end else begin
                    tries_nxt = tries_r + 2'd1;
                    cand_nxt  = (tries_r == 2'd2) ? dir_rev(dir_r) : dir_rot(cand_r, dir_r);
                    {wq_x_nxt, wq_y_nxt} = nb_tile(cand_nxt, tile_x_s, tile_y_s);
                    state_nxt = ST_QUERY;
                end
            end
            ST_COMMIT: begin
                dir_nxt = cand_r;
                if (!boxed_r) begin
                    {x_nxt, y_nxt} = step_pix(cand_r, x_r, y_r);
                end else begin
                    {x_nxt, y_nxt} = {x_r, y_r};
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= ST_IDLE;
            x_r     <= X_RST;
            y_r     <= Y_RST;
            dir_r   <= DIR_LEFT;
            cand_r  <= DIR_LEFT;
            tries_r <= 2'd0;
            boxed_r <= 1'b0;
            pend_r  <= 1'b0;
            wq_x_r  <= 5'd0;
            wq_y_r  <= 5'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            x_r     <= x_nxt;
            y_r     <= y_nxt;
            dir_r   <= dir_nxt;
            cand_r  <= cand_nxt;
            tries_r <= tries_nxt;
            boxed_r <= boxed_nxt;
            pend_r  <= pend_nxt;
            wq_x_r  <= wq_x_nxt;
            wq_y_r  <= wq_y_nxt;
            busy_r  <= (state_nxt != ST_IDLE);
        end
    end

    assign ghost_x   = x_r;
    assign ghost_y   = y_r;
    assign ghost_dir = dir_r;
    assign busy      = busy_r;
    assign wall_q_x  = wq_x_r;
    assign wall_q_y  = wq_y_r;

endmodule
